// File: rtl/color_fade_pkg.sv
// Shared types for the colour fade driver: colour codes, fade FSM states and
// the colour-to-channel enable map.
package color_fade_pkg;

    typedef enum logic [1:0] {
        COLOR_OFF   = 2'h0,
        COLOR_BLUE  = 2'h1,
        COLOR_RED   = 2'h2,
        COLOR_WHITE = 2'h3
    } color_code_t;

    typedef enum logic [1:0] {
        STEADY    = 2'd0,
        FADE_DOWN = 2'd1,
        FADE_UP   = 2'd2
    } fade_state_t;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } chan_en_t;

    function automatic chan_en_t color_to_en(input color_code_t code);
        chan_en_t en;
        en = '0;
        case (code)
            COLOR_BLUE:  en.b = 1'b1;
            COLOR_RED:   en.r = 1'b1;
            COLOR_WHITE: en = '{r: 1'b1, g: 1'b1, b: 1'b1};
            default:     en = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/color_fade_if.sv
// Colour code in, PWM LED drives and fade status out.
interface color_fade_if;
    logic [1:0] color_in;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       fading;

    modport master (output color_in, input led_r, led_g, led_b, fading);
    modport slave  (input color_in, output led_r, led_g, led_b, fading);
endinterface

// File: rtl/color_fade_channel.sv
// One PWM channel: owns its duty level and registered LED drive.
// COLOR_FADE_RAMP_EN selects single-step ramping instead of direct level loads.
module color_fade_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    input  logic                 en,
`ifdef COLOR_FADE_RAMP_EN
    input  logic                 step_up,
    input  logic                 step_down,
    output logic                 at_level,
    output logic                 at_zero,
`else
    input  logic                 load,
`endif
    output logic                 led
);

    localparam logic [PWM_WIDTH-1:0] FULL = {PWM_WIDTH{1'b1}};

    logic [PWM_WIDTH-1:0] duty_q, duty_d;
    logic [PWM_WIDTH-1:0] level;
    logic                 led_q, led_d;

    assign level = en ? FULL : '0;

    // Ramping saturates at 0 and at the mapped level, so duties never wrap.
    always_comb begin
        duty_d = duty_q;
`ifdef COLOR_FADE_RAMP_EN
        if (step_down && (duty_q != '0)) begin
            duty_d = duty_q - PWM_WIDTH'(1);
        end else if (step_up && (duty_q < level)) begin
            duty_d = duty_q + PWM_WIDTH'(1);
        end
`else
        if (load) begin
            duty_d = level;
        end
`endif
        led_d = (pwm_cnt < duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

`ifdef COLOR_FADE_RAMP_EN
    assign at_level = (duty_q == level);
    assign at_zero  = (duty_q == '0);
`endif

    assign led = led_q;

endmodule

// File: rtl/color_fade_driver.sv
// Turns the colour FSM's code into three PWM LED drives, fading through black
// on every colour change when COLOR_FADE_RAMP_EN is defined.
module color_fade_driver
    import color_fade_pkg::*;
#(
    parameter int PWM_WIDTH = 8,
    parameter int STEP_DIV  = 4
) (
    input logic         clk,
    input logic         rst_n,
    color_fade_if.slave bus
);

    color_code_t          color_q, color_d;
    color_code_t          target_q, target_d;
    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    chan_en_t             chan_en;

    always_comb begin
        color_d   = color_code_t'(bus.color_in);
        pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q   <= COLOR_OFF;
            target_q  <= COLOR_OFF;
            pwm_cnt_q <= '0;
        end else begin
            color_q   <= color_d;
            target_q  <= target_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

`ifdef COLOR_FADE_RAMP_EN
    localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

    fade_state_t     state_q, state_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic            fading_q, fading_d;
    logic            tick, step_up, step_down;
    logic            all_zero, all_level;
    logic            at_level_r, at_level_g, at_level_b;
    logic            at_zero_r, at_zero_g, at_zero_b;

    assign chan_en = color_to_en(target_q);

    // Done conditions are checked before the tick; a redirect out of FADE_UP
    // suppresses that cycle's step so duties head down from where they are.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        step_up   = 1'b0;
        step_down = 1'b0;
        tick      = (presc_q == PS_LAST);
        all_zero  = at_zero_r & at_zero_g & at_zero_b;
        all_level = at_level_r & at_level_g & at_level_b;
        case (state_q)
            STEADY: begin
                if (color_q != target_q) begin
                    target_d = color_q;
                    state_d  = FADE_DOWN;
                end
            end
            FADE_DOWN: begin
                if (color_q != target_q) begin
                    target_d = color_q;
                end
                if (all_zero) begin
                    state_d = FADE_UP;
                end else begin
                    step_down = tick;
                end
            end
            FADE_UP: begin
                if (color_q != target_q) begin
                    target_d = color_q;
                    state_d  = FADE_DOWN;
                end else if (all_level) begin
                    state_d = STEADY;
                end else begin
                    step_up = tick;
                end
            end
            default: state_d = STEADY;
        endcase

        if ((state_d != state_q) || (state_d == STEADY) || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PS_W'(1);
        end
        fading_d = (state_d != STEADY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= STEADY;
            presc_q  <= '0;
            fading_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            fading_q <= fading_d;
        end
    end

    assign bus.fading = fading_q;
`else
    logic load;

    // Without ramping, duties jump straight to the new colour's levels.
    always_comb begin
        target_d = color_q;
        load     = (color_q != target_q);
        chan_en  = color_to_en(color_q);
    end

    assign bus.fading = 1'b0;
`endif

    color_fade_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_cnt  (pwm_cnt_q),
        .en       (chan_en.r),
`ifdef COLOR_FADE_RAMP_EN
        .step_up  (step_up),
        .step_down(step_down),
        .at_level (at_level_r),
        .at_zero  (at_zero_r),
`else
        .load     (load),
`endif
        .led      (bus.led_r)
    );

    color_fade_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch_g (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_cnt  (pwm_cnt_q),
        .en       (chan_en.g),
`ifdef COLOR_FADE_RAMP_EN
        .step_up  (step_up),
        .step_down(step_down),
        .at_level (at_level_g),
        .at_zero  (at_zero_g),
`else
        .load     (load),
`endif
        .led      (bus.led_g)
    );

    color_fade_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_cnt  (pwm_cnt_q),
        .en       (chan_en.b),
`ifdef COLOR_FADE_RAMP_EN
        .step_up  (step_up),
        .step_down(step_down),
        .at_level (at_level_b),
        .at_zero  (at_zero_b),
`else
        .load     (load),
`endif
        .led      (bus.led_b)
    );

endmodule

// File: doc/color_fade_driver.md
# color_fade_driver

Downstream consumer of the colour-state FSM's 2-bit colour code. Turns the code into three PWM LED drives (red, green, blue). Every colour change is a fade: all channels ramp down to zero, then the new colour's channels ramp up to full. Sits between the colour FSM output and the board-level LED pins, in the same clock domain.

## Interface
- PWM_WIDTH, 8: duty/counter resolution in bits; full level = 2^PWM_WIDTH-1.
- STEP_DIV, 4: clock cycles per ramp step (must be ≥1).
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- color_in  input  2  colour code from the colour FSM, same clock domain.
- led_r  output  1  red PWM drive.
- led_g  output  1  green PWM drive.
- led_b  output  1  blue PWM drive.
- fading  output  1  high while a fade is in progress.

## Operation
- Colour map (code → full-level channels): 0 OFF → none; 1 BLUE → b; 2 RED → r; 3 WHITE → r, g, b.
- color_q: color_in registered every cycle. All decisions use color_q.
- target: the latched colour code. duty_r, duty_g, duty_b: PWM_WIDTH-bit levels.
- pwm_cnt: free-running PWM_WIDTH-bit counter that wraps at 2^PWM_WIDTH-1 → 0.
- led_x = (pwm_cnt < duty_x), registered:
  - duty 0 → always low.
  - full level → high 2^W-1 of every 2^W cycles.
- Step prescaler counts 0..STEP_DIV-1 and is cleared on every state change. A step tick occurs when prescaler == STEP_DIV-1.
- FSM states:
  - STEADY:
    - If color_q != target: target ← color_q, go to FADE_DOWN.
    - Otherwise duties hold.
  - FADE_DOWN:
    - On each tick, every nonzero duty decrements by 1.
    - When all duties are 0, go to FADE_UP. This is evaluated before the tick, so all-zero on entry exits after 1 cycle.
    - If color_q != target, target ← color_q, with no extra cycle and no state change.
  - FADE_UP:
    - On each tick, every duty below its mapped level increments by 1.
    - When all duties equal their mapped levels, go to STEADY.
    - If color_q != target: target ← color_q, go to FADE_DOWN. Duties continue down from their current values.
- fading = (state != STEADY), registered with the state.
- Invariants:
  - Duties never wrap.
  - Duties never exceed full level.
  - Two different colours' channels never rise at the same time.

## Timing
- Reset values (asynchronous, while rst_n = 0): led_r/g/b = 0, fading = 0, state STEADY, target 0, color_q 0, all duties 0, pwm_cnt 0, prescaler 0.
- color_in change at edge n is in color_q at n+1. STEADY→FADE_DOWN occurs at n+2, and fading is high from that point.
- A full ramp (0 → full, or full → 0) takes (2^PWM_WIDTH-1)·STEP_DIV cycles.
- Duty change to LED: a new duty takes effect on led_x at the next clock edge.
- Reset asserted mid-fade: outputs go to 0 immediately. After release, the block fades up to color_q if nonzero.

## Configuration
- COLOR_FADE_RAMP_EN defined: fade behaviour as above.
- COLOR_FADE_RAMP_EN undefined:
  - No FADE states and no prescaler.
  - Duties load their mapped levels at the edge after color_q != target, together with target.
  - fading is tied to 0.

## Structure
- Package color_fade_pkg holds:
  - color_code_t enum: COLOR_OFF = 2'h0, COLOR_BLUE = 2'h1, COLOR_RED = 2'h2, COLOR_WHITE = 2'h3.
  - fade_state_t enum: STEADY, FADE_DOWN, FADE_UP.
  - Function mapping a code to per-channel enables.
- Sub-module color_fade_channel, instantiated 3×:
  - Owns duty_x and its inc/dec/load logic.
  - Contains the comparator against the shared pwm_cnt.
  - Generates the registered led_x.
- Top level holds the FSM, color_q, target, prescaler and pwm_cnt.

## Test plan
All scenarios use PWM_WIDTH = 4 and STEP_DIV = 2.
- Reset with color_in = 2, then release → fading rises 2 cycles after release. FADE_DOWN lasts 1 cycle. duty_r reaches 15 after 30 FADE_UP cycles, then fading falls. led_r is high 15 of every 16 cycles; led_g and led_b stay 0.
- Steady RED, color_in → 1 → red ramps 15→0 over 30 cycles, then blue ramps 0→15 over 30 cycles. led_r and led_b are never both active within one 16-cycle PWM window.
- In FADE_UP toward RED at duty_r = 7, color_in → 3 → FADE_DOWN next cycle, duty_r decreases from 7 to 0, then r, g and b rise together to 15.
- In FADE_DOWN, color_in 1 → 0 → 1 within 3 cycles → fade down completes, then blue ramps up. No restart and no stall.
- rst_n low mid-ramp at duty_b = 9 → all LEDs and fading are 0 in the same cycle. After release with color_in = 0, fading stays 0.
- COLOR_FADE_RAMP_EN undefined, color_in 2 → 1 → duty_b = 15 and duty_r = 0 two edges after the change; fading is always 0.
